// File: rtl/ysyx_23060236_tlb_pkg.sv
// rtl/ysyx_23060236_tlb_pkg.sv - shared Sv32 TLB constants (optional perf counters: YSYX_23060236_TLB_PERF_EN)
package ysyx_23060236_tlb_pkg;
  localparam int VPN_W       = 20;
  localparam int PPN_W       = 20;
  localparam int TLB_ENTRIES = 8;
endpackage

// File: rtl/ysyx_23060236_tlb_victim.sv
// rtl/ysyx_23060236_tlb_victim.sv - refill slot selection: existing VPN, first free entry, else round-robin
module ysyx_23060236_tlb_victim
  import ysyx_23060236_tlb_pkg::*;
#(
  parameter int ENTRIES = TLB_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          wvalid,
  input  logic [VPN_W-1:0]              awaddr,
  input  logic [ENTRIES-1:0]            valid,
  input  logic [ENTRIES-1:0][VPN_W-1:0] vpn,
  output logic [IDX_W-1:0]              widx
);
  logic             match_found;
  logic [IDX_W-1:0] match_idx;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] rp;

  // Scan high to low so the lowest index wins both encoders.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && vpn[i] == awaddr) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(i);
      end
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    widx = rp;
    if (match_found)
      widx = match_idx;
    else if (free_found)
      widx = free_idx;
  end

  // ENTRIES is a power of two, so the natural wrap of rp is mod ENTRIES.
  always_ff @(posedge clock) begin
    if (reset || flush)
      rp <= '0;
    else if (wvalid && !match_found && !free_found)
      rp <= rp + 1'b1;
  end
endmodule

// File: rtl/ysyx_23060236_tlb.sv
// rtl/ysyx_23060236_tlb.sv - fully-associative Sv32 TLB; perf counters under YSYX_23060236_TLB_PERF_EN
module ysyx_23060236_tlb
  import ysyx_23060236_tlb_pkg::*;
#(
  parameter int ENTRIES = TLB_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [VPN_W-1:0] tlb_araddr,
  input  logic             tlb_rvalid,
  output logic             tlb_hit,
  output logic [PPN_W-1:0] tlb_rdata,
  input  logic [VPN_W-1:0] tlb_awaddr,
  input  logic [PPN_W-1:0] tlb_wdata,
  input  logic             tlb_wvalid,
`ifdef YSYX_23060236_TLB_PERF_EN
  output logic [31:0]      perf_hit_cnt,
  output logic [31:0]      perf_miss_cnt,
  output logic [31:0]      perf_evict_cnt,
`endif
  input  logic             tlb_flush
);
  logic [ENTRIES-1:0]            valid;
  logic [ENTRIES-1:0][VPN_W-1:0] vpn;
  logic [ENTRIES-1:0][PPN_W-1:0] ppn;
  logic [IDX_W-1:0]              widx;
  logic                          do_write;
  logic                          lookup_hit;
  logic [PPN_W-1:0]              lookup_ppn;

  assign do_write = tlb_wvalid && !tlb_flush;

  ysyx_23060236_tlb_victim #(
    .ENTRIES(ENTRIES),
    .IDX_W  (IDX_W)
  ) u_victim (
    .clock (clock),
    .reset (reset),
    .flush (tlb_flush),
    .wvalid(do_write),
    .awaddr(tlb_awaddr),
    .valid (valid),
    .vpn   (vpn),
    .widx  (widx)
  );

  always_comb begin
    lookup_hit = 1'b0;
    lookup_ppn = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && vpn[i] == tlb_araddr) begin
        lookup_hit = 1'b1;
        lookup_ppn = ppn[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || tlb_flush)
      valid <= '0;
    else if (do_write)
      valid[widx] <= 1'b1;
  end

  // Tags and PPNs are qualified by valid, so they carry no reset.
  always_ff @(posedge clock) begin
    if (!reset && do_write) begin
      vpn[widx] <= tlb_awaddr;
      ppn[widx] <= tlb_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tlb_hit   <= 1'b0;
      tlb_rdata <= '0;
    end else if (tlb_flush) begin
      tlb_hit <= 1'b0;
    end else begin
      tlb_hit <= tlb_rvalid && lookup_hit;
      if (tlb_rvalid && lookup_hit)
        tlb_rdata <= lookup_ppn;
    end
  end

`ifdef YSYX_23060236_TLB_PERF_EN
  logic evict;
  assign evict = do_write && valid[widx] && vpn[widx] != tlb_awaddr;

  always_ff @(posedge clock) begin
    if (reset || tlb_flush) begin
      perf_hit_cnt   <= '0;
      perf_miss_cnt  <= '0;
      perf_evict_cnt <= '0;
    end else begin
      if (tlb_rvalid && lookup_hit)
        perf_hit_cnt <= perf_hit_cnt + 32'd1;
      if (tlb_rvalid && !lookup_hit)
        perf_miss_cnt <= perf_miss_cnt + 32'd1;
      if (evict)
        perf_evict_cnt <= perf_evict_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ysyx_23060236_tlb.sv
// tb/tb_ysyx_23060236_tlb.sv - directed bench for ysyx_23060236_tlb
module tb_ysyx_23060236_tlb;
  logic        clock = 1'b0;
  logic        reset;
  logic [19:0] tlb_araddr;
  logic        tlb_rvalid;
  logic        tlb_hit;
  logic [19:0] tlb_rdata;
  logic [19:0] tlb_awaddr;
  logic [19:0] tlb_wdata;
  logic        tlb_wvalid;
  logic        tlb_flush;
`ifdef YSYX_23060236_TLB_PERF_EN
  logic [31:0] perf_hit_cnt;
  logic [31:0] perf_miss_cnt;
  logic [31:0] perf_evict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ysyx_23060236_tlb dut (
    .clock     (clock),
    .reset     (reset),
    .tlb_araddr(tlb_araddr),
    .tlb_rvalid(tlb_rvalid),
    .tlb_hit   (tlb_hit),
    .tlb_rdata (tlb_rdata),
    .tlb_awaddr(tlb_awaddr),
    .tlb_wdata (tlb_wdata),
    .tlb_wvalid(tlb_wvalid),
`ifdef YSYX_23060236_TLB_PERF_EN
    .perf_hit_cnt  (perf_hit_cnt),
    .perf_miss_cnt (perf_miss_cnt),
    .perf_evict_cnt(perf_evict_cnt),
`endif
    .tlb_flush (tlb_flush)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic refill(input logic [19:0] v, input logic [19:0] p);
    tlb_wvalid = 1'b1;
    tlb_awaddr = v;
    tlb_wdata  = p;
    step();
    tlb_wvalid = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [19:0] v,
                        input logic exp_hit, input logic [19:0] exp_data);
    tlb_rvalid = 1'b1;
    tlb_araddr = v;
    step();
    tlb_rvalid = 1'b0;
    check({tag, ".hit"}, 32'(tlb_hit), 32'(exp_hit));
    check({tag, ".data"}, 32'(tlb_rdata), 32'(exp_data));
  endtask

  initial begin
    reset = 1'b1; tlb_araddr = '0; tlb_rvalid = 1'b0; tlb_awaddr = '0;
    tlb_wdata = '0; tlb_wvalid = 1'b0; tlb_flush = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("reset.hit", 32'(tlb_hit), 32'd0);
    check("reset.data", 32'(tlb_rdata), 32'd0);

    lookup("cold", 20'h12345, 1'b0, 20'h00000);

    refill(20'h12345, 20'h80001);
    lookup("hit1", 20'h12345, 1'b1, 20'h80001);
    lookup("miss_hold", 20'h12346, 1'b0, 20'h80001);
    step();
    check("idle.hit", 32'(tlb_hit), 32'd0);
    check("idle.data", 32'(tlb_rdata), 32'h80001);

    // In-place overwrite: after 7 more fills the table is exactly full.
    do_reset();
    refill(20'h12345, 20'h80001);
    refill(20'h12345, 20'h80077);
    for (int i = 0; i < 7; i++) refill(20'h00100 + 20'(i), 20'h40000 + 20'(i));
    lookup("ovw", 20'h12345, 1'b1, 20'h80077);
    lookup("ovw_last", 20'h00106, 1'b1, 20'h40006);
    refill(20'h00107, 20'h40007);
    lookup("ovw_evict", 20'h12345, 1'b0, 20'h40006);
    lookup("ovw_new", 20'h00107, 1'b1, 20'h40007);

    // Round-robin replacement once full.
    do_reset();
    for (int i = 0; i < 8; i++) refill(20'(i), 20'h80000 + 20'(i));
    refill(20'h00008, 20'h80008);
    refill(20'h00009, 20'h80009);
    lookup("rr2", 20'h00002, 1'b1, 20'h80002);
    lookup("rr0", 20'h00000, 1'b0, 20'h80002);
    lookup("rr1", 20'h00001, 1'b0, 20'h80002);
    lookup("rr9", 20'h00009, 1'b1, 20'h80009);
    lookup("rr8", 20'h00008, 1'b1, 20'h80008);
    lookup("rr7", 20'h00007, 1'b1, 20'h80007);
    refill(20'h0000A, 20'h8000A);
    lookup("rr_next", 20'h00002, 1'b0, 20'h80007);

    // Same-cycle refill and lookup sees old contents.
    do_reset();
    tlb_wvalid = 1'b1; tlb_awaddr = 20'h0ABCD; tlb_wdata = 20'h55555;
    tlb_rvalid = 1'b1; tlb_araddr = 20'h0ABCD;
    step();
    tlb_wvalid = 1'b0; tlb_rvalid = 1'b0;
    check("same.hit", 32'(tlb_hit), 32'd0);
    check("same.data", 32'(tlb_rdata), 32'd0);
    lookup("same_next", 20'h0ABCD, 1'b1, 20'h55555);

    // Flush beats a same-cycle refill and a same-cycle lookup.
    do_reset();
    for (int i = 0; i < 4; i++) refill(20'h00030 + 20'(i), 20'h70000 + 20'(i));
    lookup("pre_flush", 20'h00031, 1'b1, 20'h70001);
    tlb_flush = 1'b1;
    tlb_wvalid = 1'b1; tlb_awaddr = 20'h00042; tlb_wdata = 20'h71111;
    tlb_rvalid = 1'b1; tlb_araddr = 20'h00030;
    step();
    tlb_flush = 1'b0; tlb_wvalid = 1'b0; tlb_rvalid = 1'b0;
    check("flush.hit", 32'(tlb_hit), 32'd0);
`ifdef YSYX_23060236_TLB_PERF_EN
    check("flush.perf_hit", perf_hit_cnt, 32'd0);
    check("flush.perf_miss", perf_miss_cnt, 32'd0);
    check("flush.perf_evict", perf_evict_cnt, 32'd0);
`endif
    lookup("flush42", 20'h00042, 1'b0, 20'h70001);
    for (int i = 0; i < 4; i++) lookup("flushed", 20'h00030 + 20'(i), 1'b0, 20'h70001);
    // Entries refill from index 0 again after a flush.
    refill(20'h00050, 20'h72222);
    lookup("post_flush", 20'h00050, 1'b1, 20'h72222);

    // Reset mid-operation discards the pending lookup and refill.
    tlb_rvalid = 1'b1; tlb_araddr = 20'h00050;
    tlb_wvalid = 1'b1; tlb_awaddr = 20'h00060; tlb_wdata = 20'h73333;
    reset = 1'b1;
    step();
    reset = 1'b0; tlb_rvalid = 1'b0; tlb_wvalid = 1'b0;
    check("midrst.hit", 32'(tlb_hit), 32'd0);
    check("midrst.data", 32'(tlb_rdata), 32'd0);
    lookup("midrst50", 20'h00050, 1'b0, 20'h00000);
    lookup("midrst60", 20'h00060, 1'b0, 20'h00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
